fp_reduce_tree: RTL and testbench



---
 rtl/boost_cal_pkg.sv | 35 +++
 rtl/floating_add.sv | 94 +++++++++
 rtl/fp_reduce_tree_level.sv | 49 ++++
 rtl/fp_reduce_tree.sv | 99 +++++++++
 tb/tb_fp_reduce_tree.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boost_cal_pkg.sv
// Shared constants and elaboration helpers for the boost/cal datapath.
// Holds FP width, the +0.0 constant, adder latency and tree-shape functions.
package boost_cal_pkg;

  localparam int          FP_WIDTH       = 32;
  localparam logic [31:0] FP_ZERO        = 32'h0000_0000;
  localparam int          FP_ADD_LATENCY = 4;

  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int level_nodes(input int len, input int k);
    int n;
    n = len;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int node_offset(input int len, input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o = o + level_nodes(len, i);
    return o;
  endfunction

endpackage

// File: rtl/floating_add.sv
// Single-precision IEEE-754 adder, round-to-nearest-even, fixed latency.
// Result is computed in the first stage and carried through LATENCY regs.
module floating_add
  import boost_cal_pkg::*;
#(
  parameter int LATENCY = FP_ADD_LATENCY
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);

  function automatic logic [31:0] add_f(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [31:0] hi, lo;
    logic [9:0]  eh, el, e, d;
    logic [23:0] mh, ml;
    logic [49:0] ys;
    logic [26:0] xa, ya, m;
    logic [27:0] s;
    logic [4:0]  lz;
    logic [7:0]  ef;
    logic        up;
    logic [30:0] mag;
    logic        xnan, ynan, xinf, yinf;
    xnan = (&x[30:23]) && (|x[22:0]);
    ynan = (&y[30:23]) && (|y[22:0]);
    xinf = (&x[30:23]) && !(|x[22:0]);
    yinf = (&y[30:23]) && !(|y[22:0]);
    if (xnan || ynan) return 32'h7FC0_0000;
    if (xinf && yinf && (x[31] != y[31])) return 32'h7FC0_0000;
    if (xinf) return x;
    if (yinf) return y;
    if (x[30:0] >= y[30:0]) begin
      hi = x;
      lo = y;
    end else begin
      hi = y;
      lo = x;
    end
    eh = (hi[30:23] == 8'd0) ? 10'd1 : {2'b0, hi[30:23]};
    el = (lo[30:23] == 8'd0) ? 10'd1 : {2'b0, lo[30:23]};
    mh = {|hi[30:23], hi[22:0]};
    ml = {|lo[30:23], lo[22:0]};
    d  = eh - el;
    ys = {ml, 26'b0} >> d;
    xa = {mh, 3'b000};
    ya = {ys[49:24], |ys[23:0]};
    if (hi[31] == lo[31]) s = {1'b0, xa} + {1'b0, ya};
    else                  s = {1'b0, xa} - {1'b0, ya};
    if (s == 28'd0) return {hi[31] & lo[31], 31'b0};
    e  = eh;
    lz = 5'd0;
    if (s[27]) begin
      m = {s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      for (int i = 0; i <= 26; i++) begin
        if (s[i]) lz = 5'(26 - i);
      end
      if ({5'b0, lz} < e) begin
        m = s[26:0] << lz;
        e = e - {5'b0, lz};
      end else begin
        m = s[26:0] << (e - 10'd1);
        e = 10'd1;
      end
    end
    if (e >= 10'd255) return {hi[31], 8'hFF, 23'b0};
    ef  = m[26] ? e[7:0] : 8'd0;
    up  = m[2] & (m[1] | m[0] | m[3]);
    mag = {ef, m[25:3]} + 31'(up);
    return {hi[31], mag};
  endfunction

  logic [31:0] pipe [LATENCY];

  // Compute the sum and shift it down the fixed-latency pipe.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= add_f(a, b);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[LATENCY-1];

endmodule

// File: rtl/fp_reduce_tree_level.sv
// One level of the reduction tree: pairwise adders plus an odd-node delay.
// The delay matches the adder latency so every output node is time-aligned.
module fp_tree_level
  import boost_cal_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int DATA_WIDTH  = FP_WIDTH,
  parameter int ADD_LATENCY = FP_ADD_LATENCY,
  localparam int N_OUT      = (N_IN + 1) / 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_IN*DATA_WIDTH-1:0]  in_data,
  output logic [N_OUT*DATA_WIDTH-1:0] out_data
);

  logic areset;
  assign areset = ~rst_n;

  for (genvar j = 0; j < N_IN / 2; j++) begin : g_add
    floating_add #(
      .LATENCY (ADD_LATENCY)
    ) u_add (
      .clk    (clk),
      .areset (areset),
      .a      (in_data[(2*j)*DATA_WIDTH +: DATA_WIDTH]),
      .b      (in_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]),
      .q      (out_data[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  if (N_IN % 2 == 1) begin : g_pass
    logic [DATA_WIDTH-1:0] dly [ADD_LATENCY];

    // Delay the unpaired last node by one adder latency.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < ADD_LATENCY; i++) dly[i] <= '0;
      end else begin
        dly[0] <= in_data[(N_IN-1)*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i < ADD_LATENCY; i++) dly[i] <= dly[i-1];
      end
    end

    assign out_data[(N_OUT-1)*DATA_WIDTH +: DATA_WIDTH] =
      dly[ADD_LATENCY-1];
  end

endmodule

// File: rtl/fp_reduce_tree.sv
// Pipelined FP32 reduction tree with depth-matched valid pipeline.
// Optional FP_REDUCE_TREE_TAG_EN carries a per-vector tag to the output.
module fp_reduce_tree
  import boost_cal_pkg::*;
#(
  parameter int DATA_WIDTH  = FP_WIDTH,
  parameter int LENGTH      = 18,
  parameter int ADD_LATENCY = FP_ADD_LATENCY
`ifdef FP_REDUCE_TREE_TAG_EN
  ,
  parameter int TAG_WIDTH   = 8
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH*LENGTH-1:0] in_addends,
  input  logic [LENGTH-1:0]            in_mask,
  input  logic                         valid_in,
`ifdef FP_REDUCE_TREE_TAG_EN
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic [TAG_WIDTH-1:0]         out_tag,
`endif
  output logic [DATA_WIDTH-1:0]        out_sum,
  output logic                         valid_out
);

  localparam int LEVELS  = clog2(LENGTH);
  localparam int LATENCY = 1 + LEVELS * ADD_LATENCY;
  localparam int TOTAL   = node_offset(LENGTH, LEVELS + 1);

  if (LENGTH < 2) begin : g_bad_length
    $error("fp_reduce_tree: LENGTH must be >= 2");
  end
  if (DATA_WIDTH != FP_WIDTH) begin : g_bad_width
    $error("fp_reduce_tree: only DATA_WIDTH=32 is supported");
  end

  logic [DATA_WIDTH*LENGTH-1:0] addends;
  logic [LATENCY-1:0]           vsr;
  logic [TOTAL*DATA_WIDTH-1:0]  nodes;

  // Capture masked addends on valid cycles, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addends <= '0;
    end else if (valid_in) begin
      for (int i = 0; i < LENGTH; i++) begin
        addends[i*DATA_WIDTH +: DATA_WIDTH] <= in_mask[i] ?
          in_addends[i*DATA_WIDTH +: DATA_WIDTH] : FP_ZERO;
      end
    end
  end

  // Valid travels alongside the data through a plain shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsr <= '0;
    else        vsr <= {vsr[LATENCY-2:0], valid_in};
  end

  assign valid_out = vsr[LATENCY-1];
  assign nodes[0 +: LENGTH*DATA_WIDTH] = addends;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NI   = level_nodes(LENGTH, k);
    localparam int NO   = (NI + 1) / 2;
    localparam int IOFF = node_offset(LENGTH, k);
    localparam int OOFF = node_offset(LENGTH, k + 1);

    fp_tree_level #(
      .N_IN        (NI),
      .DATA_WIDTH  (DATA_WIDTH),
      .ADD_LATENCY (ADD_LATENCY)
    ) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (nodes[IOFF*DATA_WIDTH +: NI*DATA_WIDTH]),
      .out_data (nodes[OOFF*DATA_WIDTH +: NO*DATA_WIDTH])
    );
  end

  assign out_sum = nodes[(TOTAL-1)*DATA_WIDTH +: DATA_WIDTH];

`ifdef FP_REDUCE_TREE_TAG_EN
  logic [TAG_WIDTH-1:0] tags [LATENCY];

  // Tag follows the same depth as the valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  assign out_tag = tags[LATENCY-1];
`endif

endmodule

// File: tb/tb_fp_reduce_tree.sv
// Scoreboard bench for fp_reduce_tree: exact-sum golden model, latency,
// ordering, mid-flight reset, and odd-length (3 and 5 lane) builds.
module tb_fp_reduce_tree;
  import boost_cal_pkg::*;

  localparam int LEN  = 18;
  localparam int DW   = 32;
  localparam int LAT  = 1 + clog2(LEN) * FP_ADD_LATENCY;
  localparam int LAT3 = 1 + clog2(3) * FP_ADD_LATENCY;
  localparam int LAT5 = 1 + clog2(5) * FP_ADD_LATENCY;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LEN*DW-1:0] in_addends;
  logic [LEN-1:0]    in_mask;
  logic              valid_in;
  logic [DW-1:0]     out_sum;
  logic              valid_out;

  logic [3*DW-1:0]   a3;
  logic [2:0]        m3;
  logic              v3i, v3o;
  logic [DW-1:0]     s3;
  logic [5*DW-1:0]   a5;
  logic [4:0]        m5;
  logic              v5i, v5o;
  logic [DW-1:0]     s5;

`ifdef FP_REDUCE_TREE_TAG_EN
  logic [7:0] in_tag, out_tag, t3i, t3o, t5i, t5o;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] sum;
    int          cyc;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fp_reduce_tree #(.LENGTH(LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_addends (in_addends),
    .in_mask    (in_mask),
    .valid_in   (valid_in),
`ifdef FP_REDUCE_TREE_TAG_EN
    .in_tag     (in_tag),
    .out_tag    (out_tag),
`endif
    .out_sum    (out_sum),
    .valid_out  (valid_out)
  );

  fp_reduce_tree #(.LENGTH(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_addends (a3),
    .in_mask    (m3),
    .valid_in   (v3i),
`ifdef FP_REDUCE_TREE_TAG_EN
    .in_tag     (t3i),
    .out_tag    (t3o),
`endif
    .out_sum    (s3),
    .valid_out  (v3o)
  );

  fp_reduce_tree #(.LENGTH(5)) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_addends (a5),
    .in_mask    (m5),
    .valid_in   (v5i),
`ifdef FP_REDUCE_TREE_TAG_EN
    .in_tag     (t5i),
    .out_tag    (t5o),
`endif
    .out_sum    (s5),
    .valid_out  (v5o)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i2f(input int v);
    int          p;
    logic [31:0] sh;
    p = 0;
    for (int i = 0; i < 24; i++) if (v[i]) p = i;
    sh = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), sh[22:0]};
  endfunction

  // Exact integer sum of two normal floats, then one RNE rounding.
  function automatic logic [31:0] m_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    int                 ea, eb, emin, p, sh, ef;
    logic signed [127:0] va, vb, t;
    logic [127:0]        mag, q, rem, half;
    logic                sg;
    if (a[30:0] == 31'd0) begin
      if (b[30:0] == 31'd0) return {a[31] & b[31], 31'b0};
      return b;
    end
    if (b[30:0] == 31'd0) return a;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    emin = (ea < eb) ? ea : eb;
    va   = 128'({1'b1, a[22:0]}) << (ea - emin);
    vb   = 128'({1'b1, b[22:0]}) << (eb - emin);
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    t = va + vb;
    if (t == 0) return 32'h0;
    sg  = t[127];
    mag = sg ? 128'(-t) : 128'(t);
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 128'd1;
      if (q[24]) begin
        q  = q >> 1;
        sh = sh + 1;
      end
      ef = emin + sh;
    end else begin
      q  = mag << (23 - p);
      ef = emin - (23 - p);
    end
    return {sg, 8'(ef), q[22:0]};
  endfunction

  function automatic logic [31:0] tree_model(
    input logic [LEN*DW-1:0] d,
    input logic [LEN-1:0]    m
  );
    logic [31:0] n [LEN];
    int          cnt;
    for (int i = 0; i < LEN; i++) n[i] = m[i] ? d[i*DW +: DW] : 32'h0;
    cnt = LEN;
    while (cnt > 1) begin
      for (int j = 0; j < cnt / 2; j++) n[j] = m_add(n[2*j], n[2*j+1]);
      if (cnt % 2 == 1) n[cnt/2] = n[cnt-1];
      cnt = (cnt + 1) / 2;
    end
    return n[0];
  endfunction

  function automatic logic [LEN*DW-1:0] rand_vec();
    logic [LEN*DW-1:0] v;
    for (int i = 0; i < LEN; i++) begin
      v[i*DW +: DW] = {1'($urandom), 8'($urandom_range(134, 120)),
                       23'($urandom)};
    end
    return v;
  endfunction

  task automatic send(
    input logic [LEN*DW-1:0] d,
    input logic [LEN-1:0]    m,
    input logic [31:0]       expv
  );
    exp_t e;
    @(negedge clk);
    in_addends = d;
    in_mask    = m;
    valid_in   = 1'b1;
    e.sum = expv;
    e.cyc = cyc;
    e.tag = 8'($urandom);
`ifdef FP_REDUCE_TREE_TAG_EN
    in_tag = e.tag;
`endif
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      valid_in = 1'b0;
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Pop the oldest expectation whenever the tree reports a result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sum", out_sum, e.sum);
        check("latency", 32'(cyc - e.cyc), 32'(LAT));
`ifdef FP_REDUCE_TREE_TAG_EN
        check("tag", 32'(out_tag), 32'(e.tag));
`endif
      end
    end
  end

  initial begin
    logic [LEN*DW-1:0] d;
    int                n0, got3, got5;

    rst_n      = 1'b0;
    valid_in   = 1'b0;
    in_addends = '0;
    in_mask    = '0;
    a3 = '0; m3 = '0; v3i = 1'b0;
    a5 = '0; m5 = '0; v5i = 1'b0;
`ifdef FP_REDUCE_TREE_TAG_EN
    in_tag = '0; t3i = '0; t5i = '0;
`endif

    repeat (3) @(negedge clk);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_sum", out_sum, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < LEN; i++) d[i*DW +: DW] = 32'h3F80_0000;
    send(d, '1, 32'h4190_0000);
    drain();

    for (int i = 0; i < LEN; i++) d[i*DW +: DW] = i2f(i + 1);
    send(d, '1, 32'h432B_0000);
    send(d, 18'h001FF, 32'h4234_0000);
    send(d, '0, 32'h0000_0000);
    drain();

    for (int i = 0; i < 30; i++) begin
      d = rand_vec();
      send(d, LEN'($urandom), tree_model(d, LEN'($urandom)) ^ 32'h0);
      sb[sb.size()-1].sum = tree_model(d, in_mask);
    end
    for (int i = 0; i < 20; i++) begin
      idle($urandom_range(1, 3));
      d = rand_vec();
      send(d, '1, tree_model(d, '1));
    end
    drain();

    for (int i = 0; i < 10; i++) begin
      d = rand_vec();
      send(d, '1, tree_model(d, '1));
    end
    @(negedge clk);
    valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midreset_valid", 32'(valid_out), 32'd0);
    check("midreset_sum", out_sum, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 5; i++) begin
      @(negedge clk);
      check("post_reset_sum", out_sum, 32'h0);
    end
    d = rand_vec();
    send(d, '1, tree_model(d, '1));
    drain();

    @(negedge clk);
    a3  = {i2f(3), i2f(2), i2f(1)};
    m3  = '1;
    v3i = 1'b1;
    a5  = {i2f(5), i2f(4), i2f(3), i2f(2), i2f(1)};
    m5  = '1;
    v5i = 1'b1;
`ifdef FP_REDUCE_TREE_TAG_EN
    t3i = 8'h5A;
    t5i = 8'hC3;
`endif
    n0 = cyc;
    @(negedge clk);
    v3i = 1'b0;
    v5i = 1'b0;
    got3 = 0;
    got5 = 0;
    for (int k = 0; k < 20; k++) begin
      if (v3o) begin
        got3++;
        check("len3_sum", s3, 32'h40C0_0000);
        check("len3_latency", 32'(cyc - n0), 32'(LAT3));
`ifdef FP_REDUCE_TREE_TAG_EN
        check("len3_tag", 32'(t3o), 32'h5A);
`endif
      end
      if (v5o) begin
        got5++;
        check("len5_sum", s5, 32'h4170_0000);
        check("len5_latency", 32'(cyc - n0), 32'(LAT5));
`ifdef FP_REDUCE_TREE_TAG_EN
        check("len5_tag", 32'(t5o), 32'hC3);
`endif
      end
      @(negedge clk);
    end
    check("len3_pulses", 32'(got3), 32'd1);
    check("len5_pulses", 32'(got5), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
